me_best_match: RTL and testbench
================================

ME_BEST_MATCH -- requirements
Module: me_best_match

Interface
REQ-001 SHALL have parameter MACRO_DIM, default 16, macroblock edge in pixels.
REQ-002 SHALL have parameter SEARCH_DIM, default 48, search window edge in pixels.
REQ-003 SHALL have parameter SAD_W, default 16, SAD width in bits (16*16*255 = 65280 fits).
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin new macroblock search; clears all tracking.
REQ-007 SHALL have port sad_valid  input  1  qualifies sad for one candidate position (single-cycle pulse from ME controller valid).
REQ-008 SHALL have port sad  input  SAD_W  SAD of current candidate.
REQ-009 SHALL have port busy  output  1  high in SEARCH state.
REQ-010 SHALL have port done  output  1  one-cycle pulse when final candidate has been absorbed.
REQ-011 SHALL have port mv_valid  output  1  high while best_sad/mv_x/mv_y hold a finished result.
REQ-012 SHALL have port best_sad  output  SAD_W  minimum SAD found.
REQ-013 SHALL have port mv_x, mv_y  output  6 each  signed two's-complement motion vector of minimum.

Function
REQ-014 SHALL define R = SEARCH_DIM - MACRO_DIM + 1 (33) positions per axis, N = R*R (1089) candidates, OFF = (SEARCH_DIM - MACRO_DIM)/2 (16).
REQ-015 SHALL implement states IDLE, SEARCH, DONE; IDLE->SEARCH on start; SEARCH->DONE on absorption of candidate N; DONE->SEARCH on start; otherwise hold.
REQ-016 SHALL treat start in any state (including mid-SEARCH) as restart: col=0, row=0, best_sad=all-ones, mv_valid=0, next state SEARCH.
REQ-017 SHALL, if start and sad_valid coincide, apply restart and discard that sad.
REQ-018 SHALL ignore sad_valid in IDLE and DONE.
REQ-019 SHALL map candidates in raster order: col 0..R-1 increments per accepted sad; at col=R-1 wraps to 0 and row increments.
REQ-020 SHALL update best on accepted sad only if sad < best_sad (strict); ties keep earlier raster position.
REQ-021 SHALL always accept the first candidate of a search (initial best_sad all-ones; sad of all-ones at candidate 0 also recorded by forcing update at col=row=0).
REQ-022 SHALL store mv_x = col - OFF, mv_y = row - OFF, range -16..+16, 6-bit signed.
REQ-023 SHALL evaluate the last candidate (row=col=R-1) in the same cycle it is accepted; done and mv_valid assert the following cycle, with outputs reflecting it.
REQ-024 SHALL hold best_sad/mv_x/mv_y stable and mv_valid high throughout DONE until next start.
REQ-025 SHALL keep best_sad/mv outputs registered (no combinational path from sad to outputs).

Reset
REQ-026 SHALL on rst_n low: state IDLE, busy=0, done=0, mv_valid=0, best_sad=all-ones, mv_x=0, mv_y=0, counters 0.
REQ-027 SHALL abort any search on reset mid-operation; no done pulse follows deassertion.

Structure
REQ-028 SHALL place MACRO_DIM/SEARCH_DIM defaults, R, N, OFF, SAD_W, MV_W=6, and state enum in shared package me_pkg.
REQ-029 SHALL instantiate one sub-module me_raster_counter (col/row counters, clear, advance, last-position flag).

Verification
REQ-030 Reset then start, 1089 sads all 1000 except sad=5 at row 16 col 16 -> done once, best_sad=5, mv=(0,0).
REQ-031 All sads equal 200 -> best_sad=200, mv=(-16,-16) (first wins tie).
REQ-032 Minimum 0 at last candidate (row 32 col 32) -> done one cycle after final sad_valid, mv=(+16,+16).
REQ-033 Start asserted after 500 sads, then full 1089-sad stream with min 7 at row 0 col 32 -> only one done, best_sad=7, mv=(+16,-16).
REQ-034 rst_n pulsed low mid-search, sad_valid pulses continue with no start -> no done, mv_valid=0, outputs at reset values.
REQ-035 sad_valid pulses during DONE with sad=0 -> best_sad/mv unchanged, mv_valid stays 1.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants and state encoding for the motion-estimation best-match tracker.
package me_pkg;
    localparam int MACRO_DIM_DEF  = 16;
    localparam int SEARCH_DIM_DEF = 48;
    localparam int SAD_W_DEF      = 16;
    localparam int R              = SEARCH_DIM_DEF - MACRO_DIM_DEF + 1;
    localparam int N              = R * R;
    localparam int OFF            = (SEARCH_DIM_DEF - MACRO_DIM_DEF) / 2;
    localparam int MV_W           = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } me_state_e;
endpackage

// File: rtl/me_raster_counter.sv
// Raster-order col/row position counter over an R x R candidate grid.
module me_raster_counter #(
    parameter int R     = 33,
    parameter int CNT_W = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             first,
    output logic             last
);
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;

    assign col   = col_q;
    assign row   = row_q;
    assign first = (col_q == '0) && (row_q == '0);
    assign last  = (col_q == CNT_W'(R - 1)) && (row_q == CNT_W'(R - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == CNT_W'(R - 1)) begin
                col_d = '0;
                // Wrap the whole grid after the final candidate.
                row_d = last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/me_best_match.sv
// Tracks the minimum SAD over a raster-ordered search window and reports its motion vector.
module me_best_match
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = MACRO_DIM_DEF,
    parameter int SEARCH_DIM = SEARCH_DIM_DEF,
    parameter int SAD_W      = SAD_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sad_valid,
    input  logic [SAD_W-1:0]       sad,
    output logic                   busy,
    output logic                   done,
    output logic                   mv_valid,
    output logic [SAD_W-1:0]       best_sad,
    output logic signed [MV_W-1:0] mv_x,
    output logic signed [MV_W-1:0] mv_y
);
    localparam int RANGE  = SEARCH_DIM - MACRO_DIM + 1;
    localparam int CENTER = (SEARCH_DIM - MACRO_DIM) / 2;
    localparam int CNT_W  = $clog2(RANGE);

    me_state_e        state_q, state_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [MV_W-1:0]  mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic             mv_valid_q, mv_valid_d;
    logic             done_q, done_d;

    logic             accept;
    logic [CNT_W-1:0] col, row;
    logic             first, last;

    // A coincident start wins: the sad in that cycle is dropped.
    assign accept = (state_q == ST_SEARCH) && sad_valid && !start;

    me_raster_counter #(.R(RANGE), .CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start),
        .advance (accept),
        .col     (col),
        .row     (row),
        .first   (first),
        .last    (last)
    );

    always_comb begin
        state_d    = state_q;
        best_sad_d = best_sad_q;
        mv_x_d     = mv_x_q;
        mv_y_d     = mv_y_q;
        mv_valid_d = mv_valid_q;
        done_d     = 1'b0;
        if (start) begin
            state_d    = ST_SEARCH;
            best_sad_d = '1;
            mv_valid_d = 1'b0;
        end else if (accept) begin
            // Forced update at the first candidate so an all-ones SAD still records a vector.
            if (first || (sad < best_sad_q)) begin
                best_sad_d = sad;
                mv_x_d     = MV_W'(col) - MV_W'(CENTER);
                mv_y_d     = MV_W'(row) - MV_W'(CENTER);
            end
            if (last) begin
                state_d    = ST_DONE;
                done_d     = 1'b1;
                mv_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            best_sad_q <= '1;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
            mv_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            best_sad_q <= best_sad_d;
            mv_x_q     <= mv_x_d;
            mv_y_q     <= mv_y_d;
            mv_valid_q <= mv_valid_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == ST_SEARCH);
    assign done     = done_q;
    assign mv_valid = mv_valid_q;
    assign best_sad = best_sad_q;
    assign mv_x     = mv_x_q;
    assign mv_y     = mv_y_q;
endmodule

// File: tb/tb_me_best_match.sv
// Directed, table-driven check of me_best_match: full-window streams plus restart/reset/done corners.
module tb_me_best_match;
    localparam int RR = 33;
    localparam int NN = RR * RR;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sad_valid = 1'b0;
    logic [15:0]       sad = '0;
    logic              busy, done, mv_valid;
    logic [15:0]       best_sad;
    logic signed [5:0] mv_x, mv_y;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    me_best_match dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sad_valid (sad_valid),
        .sad       (sad),
        .busy      (busy),
        .done      (done),
        .mv_valid  (mv_valid),
        .best_sad  (best_sad),
        .mv_x      (mv_x),
        .mv_y      (mv_y)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        string       name;
        int          min_pos;   // -1: no distinct minimum
        logic [15:0] min_val;
        logic [15:0] bg_val;
        logic [15:0] exp_sad;
        int          exp_mx;
        int          exp_my;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic with_sad);
        @(negedge clk);
        start = 1'b1;
        sad_valid = with_sad;
        sad = 16'd0;
        @(negedge clk);
        start = 1'b0;
        sad_valid = 1'b0;
    endtask

    // Drives cnt sads from the current negedge; leaves sad_valid high on exit.
    task automatic stream(input int cnt, input int min_pos, input logic [15:0] min_val,
                          input logic [15:0] bg_val);
        for (int i = 0; i < cnt; i++) begin
            sad_valid = 1'b1;
            sad = (i == min_pos) ? min_val : bg_val;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input logic [15:0] es, input int ex, input int ey);
        chk({name, ".best_sad"}, int'(best_sad), int'(es));
        chk({name, ".mv_x"}, int'(mv_x), ex);
        chk({name, ".mv_y"}, int'(mv_y), ey);
    endtask

    // Full search ending exactly as the last sad is absorbed.
    task automatic full_search(input string name, input int min_pos, input logic [15:0] min_val,
                               input logic [15:0] bg_val, input logic [15:0] es, input int ex,
                               input int ey);
        int d0;
        d0 = done_cnt;
        chk({name, ".busy"}, int'(busy), 1);
        chk({name, ".mv_valid_clr"}, int'(mv_valid), 0);
        stream(NN - 1, min_pos, min_val, bg_val);
        sad_valid = 1'b1;
        sad = (min_pos == NN - 1) ? min_val : bg_val;
        @(negedge clk);
        sad_valid = 1'b0;
        chk({name, ".done_timing"}, int'(done), 1);
        chk({name, ".mv_valid"}, int'(mv_valid), 1);
        check_result(name, es, ex, ey);
        @(negedge clk);
        chk({name, ".done_pulse"}, int'(done), 0);
        chk({name, ".busy_off"}, int'(busy), 0);
        chk({name, ".done_count"}, done_cnt - d0, 1);
    endtask

    vec_t vecs[5];

    initial begin
        int d0;
        vecs[0] = '{"center_min", 16 * RR + 16, 16'd5, 16'd1000, 16'd5, 0, 0};
        vecs[1] = '{"all_equal", -1, 16'd0, 16'd200, 16'd200, -16, -16};
        vecs[2] = '{"last_min", NN - 1, 16'd0, 16'd1000, 16'd0, 16, 16};
        vecs[3] = '{"all_ones", -1, 16'd0, 16'hFFFF, 16'hFFFF, -16, -16};
        vecs[4] = '{"row0_col32", 32, 16'd7, 16'd900, 16'd7, 16, -16};

        repeat (3) @(negedge clk);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.mv_valid", int'(mv_valid), 0);
        check_result("reset", 16'hFFFF, 0, 0);
        rst_n = 1'b1;

        // Ignored while idle.
        sad_valid = 1'b1; sad = 16'd3;
        repeat (3) @(negedge clk);
        sad_valid = 1'b0;
        chk("idle.busy", int'(busy), 0);
        check_result("idle", 16'hFFFF, 0, 0);

        foreach (vecs[k]) begin
            do_start(1'b0);
            chk({vecs[k].name, ".start_best"}, int'(best_sad), 16'hFFFF);
            full_search(vecs[k].name, vecs[k].min_pos, vecs[k].min_val, vecs[k].bg_val,
                        vecs[k].exp_sad, vecs[k].exp_mx, vecs[k].exp_my);
        end

        // sad_valid in DONE must not disturb the held result.
        d0 = done_cnt;
        stream(5, 0, 16'd0, 16'd0);
        sad_valid = 1'b0;
        @(negedge clk);
        chk("done_ignore.mv_valid", int'(mv_valid), 1);
        chk("done_ignore.no_done", done_cnt - d0, 0);
        check_result("done_ignore", 16'd7, 16, -16);

        // Restart mid-search after 500 sads.
        d0 = done_cnt;
        do_start(1'b0);
        stream(500, 3, 16'd1, 16'd600);
        do_start(1'b0);
        full_search("restart", 32, 16'd7, 16'd1000, 16'd7, 16, -16);
        chk("restart.single_done", done_cnt - d0, 1);

        // Coincident start and sad_valid: that sad (0) is dropped.
        do_start(1'b1);
        full_search("start_with_sad", -1, 16'd0, 16'd50, 16'd50, -16, -16);

        // Reset mid-search, sads keep coming without start.
        d0 = done_cnt;
        do_start(1'b0);
        stream(300, 10, 16'd2, 16'd400);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stream(NN + 5, 0, 16'd1, 16'd1);
        sad_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid.no_done", done_cnt - d0, 0);
        chk("rst_mid.mv_valid", int'(mv_valid), 0);
        chk("rst_mid.busy", int'(busy), 0);
        check_result("rst_mid", 16'hFFFF, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1);
    end
endmodule
